// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI target with one-byte transmit buffer and selectable CPOL/CPHA
//
// Purpose: byte-oriented SPI target sampled entirely in the system clock domain.
// sclk, cs and pico pass through two-flop synchronizers and sclk edges are found
// by comparing the synchronized level with its previous value, so sclk must run
// at clock/8 or slower.
//
// Ports:
//   clock, reset        system clock (rising edge) and async active-low reset
//   sclk, pico, cs      SPI serial clock, controller data in, active-low select
//   poci, poci_oe       target data out and its pin enable (enable only when selected)
//   tx_data, tx_valid   byte offered to the one-entry transmit buffer
//   tx_ready            buffer can take a byte this cycle
//   rx_data, rx_valid   last complete received byte; rx_valid pulses one cycle after it updates
//   underrun            pulses when a byte is loaded while the buffer is empty (0x00 sent)
//   busy                high while selected
module spi_target #(
  parameter logic CPOL = 1'b0,
  parameter logic CPHA = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sclk,
  input  logic       pico,
  input  logic       cs,
  output logic       poci,
  output logic       poci_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       underrun,
  output logic       busy
);

  localparam logic IDLE     = 1'b0;
  localparam logic SELECTED = 1'b1;

  logic       sclk_meta, sclk_sync, sclk_prev;
  logic       cs_meta, cs_sync;
  logic       pico_meta, pico_sync;
  logic [1:0] warm;
  logic       armed;
  logic       state;
  logic [2:0] bit_cnt;
  logic [6:0] shift_in;
  logic [7:0] out_reg;
  logic [7:0] buf_data;
  logic       buf_full;
  logic       rx_pend;

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic active, go_select, leave;
  logic do_sample, do_load, do_shift, accept;

  assign lead_edge   = (sclk_sync != CPOL) && (sclk_prev == CPOL);
  assign trail_edge  = (sclk_sync == CPOL) && (sclk_prev != CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  // armed only after the synchronizer holds a real pin value that was high, so
  // a cs held low across reset release does not start a transfer.
  assign go_select = (state == IDLE) && armed && !cs_sync;
  assign leave     = (state == SELECTED) && cs_sync;
  assign active    = (state == SELECTED) && !cs_sync;

  assign do_sample = active && sample_edge;
  // A shift edge seen with the bit counter at 0 starts a new byte: for CPHA=1 it
  // is the first edge of the byte, for CPHA=0 it follows the 8th sample.
  assign do_load   = (!CPHA && go_select) || (active && shift_edge && (bit_cnt == 3'd0));
  assign do_shift  = active && shift_edge && (bit_cnt != 3'd0);

  // The slot freed by a load can be refilled in the same cycle.
  assign tx_ready = !buf_full || do_load;
  assign accept   = tx_valid && tx_ready;

  assign busy    = (state == SELECTED);
  assign poci_oe = busy;
  assign poci    = busy && out_reg[7];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sclk_meta <= CPOL;
      sclk_sync <= CPOL;
      sclk_prev <= CPOL;
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      pico_meta <= 1'b0;
      pico_sync <= 1'b0;
      warm      <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sclk_meta <= sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      cs_meta   <= cs;
      cs_sync   <= cs_meta;
      pico_meta <= pico;
      pico_sync <= pico_meta;
      warm      <= {warm[0], 1'b1};
      armed     <= armed || (warm[1] && cs_sync);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shift_in <= 7'd0;
      rx_data  <= 8'h00;
      rx_pend  <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      if (go_select) begin
        state <= SELECTED;
      end else if (leave) begin
        state <= IDLE;
      end

      rx_pend  <= 1'b0;
      rx_valid <= rx_pend;
      if (leave) begin
        bit_cnt <= 3'd0;
      end else if (do_sample) begin
        bit_cnt  <= bit_cnt + 3'd1;
        shift_in <= {shift_in[5:0], pico_sync};
        if (bit_cnt == 3'd7) begin
          rx_data <= {shift_in, pico_sync};
          rx_pend <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_reg  <= 8'h00;
      buf_data <= 8'h00;
      buf_full <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= do_load && !buf_full;
      if (do_load) begin
        out_reg <= buf_full ? buf_data : 8'h00;
      end else if (do_shift) begin
        out_reg <= {out_reg[6:0], 1'b0};
      end

      if (accept) begin
        buf_data <= tx_data;
        buf_full <= 1'b1;
      end else if (do_load) begin
        buf_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - self-checking bench for spi_target in modes (0,0) and (1,1)
module tb_spi_target;

  localparam int HALF = 6;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset;
  logic [1:0]      sclk_v, cs_v, pico_v, txv_v, watch;
  logic [1:0][7:0] txd_v;
  wire  [1:0]      poci_v, oe_v, txr_v, rxv_v, und_v, busy_v;
  wire  [1:0][7:0] rxd_v;

  spi_target #(.CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clock(clock), .reset(reset), .sclk(sclk_v[0]), .pico(pico_v[0]), .cs(cs_v[0]),
    .poci(poci_v[0]), .poci_oe(oe_v[0]), .tx_data(txd_v[0]), .tx_valid(txv_v[0]),
    .tx_ready(txr_v[0]), .rx_data(rxd_v[0]), .rx_valid(rxv_v[0]), .underrun(und_v[0]),
    .busy(busy_v[0])
  );

  spi_target #(.CPOL(1'b1), .CPHA(1'b1)) dut1 (
    .clock(clock), .reset(reset), .sclk(sclk_v[1]), .pico(pico_v[1]), .cs(cs_v[1]),
    .poci(poci_v[1]), .poci_oe(oe_v[1]), .tx_data(txd_v[1]), .tx_valid(txv_v[1]),
    .tx_ready(txr_v[1]), .rx_data(rxd_v[1]), .rx_valid(rxv_v[1]), .underrun(und_v[1]),
    .busy(busy_v[1])
  );

  int n_run = 0;
  int n_fail = 0;

  // reference model: one-entry buffer per target, expected underrun totals
  logic [1:0]      mbuf_full;
  logic [1:0][7:0] mbuf;
  int              exp_und[2] = '{0, 0};

  // observations
  int         und_cnt[2]  = '{0, 0};
  int         busy_low[2] = '{0, 0};
  logic [7:0] rxq0[$];
  logic [7:0] rxq1[$];

  always @(negedge clock) begin
    if (rxv_v[0]) rxq0.push_back(rxd_v[0]);
    if (rxv_v[1]) rxq1.push_back(rxd_v[1]);
    for (int i = 0; i < 2; i++) begin
      if (und_v[i]) und_cnt[i]++;
      if (watch[i] && !busy_v[i]) busy_low[i]++;
    end
  end

  initial begin
    #600000;
    $error("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [7:0] m_load(input int w);
    logic [7:0] v;
    if (mbuf_full[w]) begin
      v = mbuf[w];
      mbuf_full[w] = 1'b0;
    end else begin
      v = 8'h00;
      exp_und[w]++;
    end
    return v;
  endfunction

  function automatic void m_push(input int w, input logic [7:0] b);
    mbuf[w] = b;
    mbuf_full[w] = 1'b1;
  endfunction

  task automatic push(input int w, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clock);
    txd_v[w] = b;
    txv_v[w] = 1'b1;
    while (!txr_v[w] && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("push_accepted_in_time", 32'(n < 400), 32'd1);
    @(negedge clock);
    txv_v[w] = 1'b0;
  endtask

  // controller side of nbits bit times, MSB first; poci captured just before the sample edge
  task automatic xfer(input int w, input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
    miso = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      pico_v[w] = mosi[i];
      if (w == 1) sclk_v[1] = 1'b0;
      wait_clk(HALF);
      miso[i] = poci_v[w];
      sclk_v[w] = 1'b1;
      wait_clk(HALF);
      if (w == 0) sclk_v[0] = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input int w, input string tag);
    chk({tag, "_poci"}, 32'(poci_v[w]), 32'd0);
    chk({tag, "_poci_oe"}, 32'(oe_v[w]), 32'd0);
    chk({tag, "_tx_ready"}, 32'(txr_v[w]), 32'd1);
    chk({tag, "_rx_data"}, 32'(rxd_v[w]), 32'd0);
    chk({tag, "_rx_valid"}, 32'(rxv_v[w]), 32'd0);
    chk({tag, "_underrun"}, 32'(und_v[w]), 32'd0);
    chk({tag, "_busy"}, 32'(busy_v[w]), 32'd0);
  endtask

  // one chip-select window of nb full bytes; loads follow the mode's rules
  task automatic transaction(input int w, input int nb, input logic [7:0] b0,
                             input logic [7:0] b1, input string tag);
    logic [7:0] mosi [2];
    logic [7:0] got, exp_b;
    mosi[0] = b0;
    mosi[1] = b1;
    if (w == 0) rxq0.delete(); else rxq1.delete();
    cs_v[w] = 1'b0;
    wait_clk(8);
    watch[w] = 1'b1;
    for (int k = 0; k < nb; k++) begin
      exp_b = m_load(w);
      xfer(w, mosi[k], 8, got);
      chk($sformatf("%s_poci_byte%0d", tag, k), 32'(got), 32'(exp_b));
    end
    wait_clk(2 * HALF);
    if (w == 0) void'(m_load(0));
    watch[w] = 1'b0;
    cs_v[w] = 1'b1;
    wait_clk(10);
    if (w == 0) begin
      chk({tag, "_rx_count"}, 32'(rxq0.size()), 32'(nb));
      for (int k = 0; k < nb && k < rxq0.size(); k++)
        chk($sformatf("%s_rx_byte%0d", tag, k), 32'(rxq0[k]), 32'(mosi[k]));
    end else begin
      chk({tag, "_rx_count"}, 32'(rxq1.size()), 32'(nb));
      for (int k = 0; k < nb && k < rxq1.size(); k++)
        chk($sformatf("%s_rx_byte%0d", tag, k), 32'(rxq1[k]), 32'(mosi[k]));
    end
    chk({tag, "_underruns"}, 32'(und_cnt[w]), 32'(exp_und[w]));
    chk({tag, "_busy_held"}, 32'(busy_low[w]), 32'd0);
    chk({tag, "_tx_ready"}, 32'(txr_v[w]), 32'(!mbuf_full[w]));
  endtask

  initial begin
    logic [7:0] got0, got1, r, rx_before;

    reset     = 1'b0;
    sclk_v    = 2'b10;
    cs_v      = 2'b11;
    pico_v    = 2'b00;
    txv_v     = 2'b00;
    txd_v     = '0;
    watch     = 2'b00;
    mbuf_full = 2'b00;
    mbuf      = '0;
    wait_clk(4);
    chk_reset_outputs(0, "reset0");
    chk_reset_outputs(1, "reset1");
    reset = 1'b1;
    wait_clk(6);

    // mode 0: preloaded 0xA5 out, 0x3C in
    m_push(0, 8'hA5);
    push(0, 8'hA5);
    chk("t035_tx_ready_full", 32'(txr_v[0]), 32'd0);
    transaction(0, 1, 8'h3C, 8'h00, "t035");

    // mode 3: two bytes in one select, buffer refilled with 0x55 right at the first load
    r = 8'($urandom);
    m_push(1, r);
    push(1, r);
    cs_v[1] = 1'b0;
    rxq1.delete();
    wait_clk(8);
    void'(m_load(1));
    m_push(1, 8'h55);
    fork
      xfer(1, 8'h81, 8, got0);
      push(1, 8'h55);
    join
    chk("t036_poci_byte0", 32'(got0), 32'(r));
    chk("t040_tx_ready_held", 32'(txr_v[1]), 32'd0);
    chk("t040_no_underrun", 32'(und_cnt[1]), 32'(exp_und[1]));
    xfer(1, 8'h7E, 8, got1);
    chk("t036_poci_byte1", 32'(got1), 32'(m_load(1)));
    wait_clk(2 * HALF);
    cs_v[1] = 1'b1;
    wait_clk(10);
    chk("t036_rx_count", 32'(rxq1.size()), 32'd2);
    if (rxq1.size() == 2) begin
      chk("t036_rx0", 32'(rxq1[0]), 32'h81);
      chk("t036_rx1", 32'(rxq1[1]), 32'h7E);
    end
    chk("t036_underruns", 32'(und_cnt[1]), 32'(exp_und[1]));
    chk("t036_tx_ready", 32'(txr_v[1]), 32'd1);

    // mode 3, empty buffer: zeros out, one underrun per byte
    transaction(1, 2, 8'($urandom), 8'($urandom), "t037");

    // mode 0, select dropped after 5 bit times
    rx_before = rxd_v[0];
    rxq0.delete();
    cs_v[0] = 1'b0;
    wait_clk(8);
    void'(m_load(0));
    xfer(0, 8'($urandom), 5, got0);
    wait_clk(HALF);
    cs_v[0] = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("t038_poci_oe_off", 32'(oe_v[0]), 32'd0);
    chk("t038_busy_off", 32'(busy_v[0]), 32'd0);
    wait_clk(10);
    chk("t038_no_rx", 32'(rxq0.size()), 32'd0);
    chk("t038_rx_data_kept", 32'(rxd_v[0]), 32'(rx_before));
    chk("t038_underruns", 32'(und_cnt[0]), 32'(exp_und[0]));
    r = 8'($urandom);
    m_push(0, r);
    push(0, r);
    transaction(0, 1, 8'($urandom), 8'h00, "t038_next");

    // mode 0, reset after bit 3 with cs still low
    r = 8'($urandom);
    m_push(0, r);
    push(0, r);
    rxq0.delete();
    cs_v[0] = 1'b0;
    wait_clk(8);
    void'(m_load(0));
    xfer(0, 8'($urandom), 3, got0);
    wait_clk(2);
    reset = 1'b0;
    #1;
    chk_reset_outputs(0, "t039_rst");
    mbuf_full = 2'b00;
    wait_clk(3);
    reset = 1'b1;
    wait_clk(12);
    chk("t039_stays_idle", 32'(busy_v[0]), 32'd0);
    chk("t039_no_rx", 32'(rxq0.size()), 32'd0);
    cs_v[0] = 1'b1;
    wait_clk(6);
    r = 8'($urandom);
    m_push(0, r);
    push(0, r);
    transaction(0, 1, 8'hF0, 8'h00, "t039_after");

    // randomized windows on both targets
    for (int it = 0; it < 3; it++) begin
      for (int w = 0; w < 2; w++) begin
        if (!mbuf_full[w] && $urandom_range(0, 1) == 1) begin
          r = 8'($urandom);
          m_push(w, r);
          push(w, r);
        end
        transaction(w, int'($urandom_range(1, 2)), 8'($urandom), 8'($urandom),
                    $sformatf("rnd%0d_%0d", it, w));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
